// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute, drives datapath
// strobes, tracks illegal opcodes and counts retired instructions.
module multicycle_controller #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [4:0]       state,
  output logic [4:0]       nextstate,
  output logic             mem_req,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             SPWrite,
  output logic [2:0]       ALUop,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [4:0] {
    FETCH    = 5'd0,
    DECODE   = 5'd1,
    ALU_EX   = 5'd2,
    ALU_WB   = 5'd3,
    MEM_ADDR = 5'd4,
    LOAD_RD  = 5'd5,
    LOAD_WB  = 5'd6,
    STORE_WR = 5'd7,
    BRANCH   = 5'd8,
    JUMP     = 5'd9,
    PUSH_DEC = 5'd10,
    PUSH_WR  = 5'd11,
    POP_RD   = 5'd12,
    POP_INC  = 5'd13,
    HALT     = 5'd14
  } state_t;

  state_t curState;
  state_t nxtState;
  logic   badOpcode;
  logic   memReqRaw, memReadRaw, memWriteRaw, irWriteRaw, pcWriteRaw;
  logic   regWriteRaw, spWriteRaw;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) curState <= FETCH;
    else       curState <= nxtState;
  end

  // Next-state decode and raw (un-gated) datapath strobes.
  always_comb begin
    nxtState    = FETCH;
    badOpcode   = 1'b0;
    memReqRaw   = 1'b0;
    memReadRaw  = 1'b0;
    memWriteRaw = 1'b0;
    irWriteRaw  = 1'b0;
    pcWriteRaw  = 1'b0;
    regWriteRaw = 1'b0;
    spWriteRaw  = 1'b0;
    ALUop       = 3'd0;
    case (curState)
      FETCH: begin
        memReqRaw  = 1'b1;
        memReadRaw = 1'b1;
        irWriteRaw = mem_ready;
        pcWriteRaw = mem_ready;
        nxtState   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        case (opcode)
          6'h00:        nxtState = ALU_EX;
          6'h01, 6'h02: nxtState = MEM_ADDR;
          6'h03:        nxtState = BRANCH;
          6'h04:        nxtState = JUMP;
          6'h05:        nxtState = PUSH_DEC;
          6'h06:        nxtState = POP_RD;
          6'h3F:        nxtState = HALT;
          default: begin
            nxtState  = FETCH;
            badOpcode = 1'b1;
          end
        endcase
      end
      ALU_EX: begin
        ALUop    = 3'd3;
        nxtState = ALU_WB;
      end
      ALU_WB: begin
        regWriteRaw = 1'b1;
        nxtState    = FETCH;
      end
      MEM_ADDR: begin
        if (opcode == 6'h01)      nxtState = LOAD_RD;
        else if (opcode == 6'h02) nxtState = STORE_WR;
        else                      nxtState = FETCH;
      end
      LOAD_RD: begin
        memReqRaw  = 1'b1;
        memReadRaw = 1'b1;
        nxtState   = mem_ready ? LOAD_WB : LOAD_RD;
      end
      LOAD_WB: begin
        regWriteRaw = 1'b1;
        nxtState    = FETCH;
      end
      STORE_WR: begin
        memReqRaw   = 1'b1;
        memWriteRaw = 1'b1;
        nxtState    = mem_ready ? FETCH : STORE_WR;
      end
      BRANCH: begin
        ALUop      = 3'd1;
        pcWriteRaw = zero;
        nxtState   = FETCH;
      end
      JUMP: begin
        pcWriteRaw = 1'b1;
        nxtState   = FETCH;
      end
      PUSH_DEC: begin
        ALUop      = 3'd1;
        spWriteRaw = 1'b1;
        nxtState   = PUSH_WR;
      end
      PUSH_WR: begin
        memReqRaw   = 1'b1;
        memWriteRaw = 1'b1;
        nxtState    = mem_ready ? FETCH : PUSH_WR;
      end
      POP_RD: begin
        memReqRaw  = 1'b1;
        memReadRaw = 1'b1;
        nxtState   = mem_ready ? POP_INC : POP_RD;
      end
      POP_INC: begin
        spWriteRaw  = 1'b1;
        regWriteRaw = 1'b1;
        nxtState    = FETCH;
      end
      HALT:    nxtState = HALT;
      default: nxtState = FETCH;
    endcase
  end

  // Reset forces state to FETCH, so strobes are gated to keep memory quiet.
  always_comb begin
    mem_req   = memReqRaw & ~Reset;
    MemRead   = memReadRaw & ~Reset;
    MemWrite  = memWriteRaw & ~Reset;
    IRWrite   = irWriteRaw & ~Reset;
    PCWrite   = pcWriteRaw & ~Reset;
    RegWrite  = regWriteRaw & ~Reset;
    SPWrite   = spWriteRaw & ~Reset;
    nextstate = Reset ? FETCH : nxtState;
    state     = curState;
    halted    = (curState == HALT);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) illegal <= 1'b0;
    else if (curState == DECODE && badOpcode) illegal <= 1'b1;
  end

  // A return to FETCH from any other state retires one instruction.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) instr_count <= '0;
    else if (nxtState == FETCH && curState != FETCH) instr_count <= instr_count + 1'b1;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic [4:0]  state;
  logic [4:0]  nextstate;
  logic        mem_req, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, SPWrite;
  logic [2:0]  ALUop;
  logic        illegal, halted;
  logic [15:0] instr_count;

  int total = 0;
  int bad   = 0;

  multicycle_controller #(.CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state(state), .nextstate(nextstate), .mem_req(mem_req), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .SPWrite(SPWrite), .ALUop(ALUop), .illegal(illegal), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic z, input logic rdy);
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Complete a fetch of 'op' and land in DECODE with mem_ready low.
  task automatic fetchOp(input logic [5:0] op);
    applyStimulus(op, 1'b0, 1'b1);
    tick();
    applyStimulus(op, 1'b0, 1'b0);
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus(6'h00, 1'b0, 1'b1);
    #20;
    checkOutput("rst_state", state, 0);
    checkOutput("rst_memreq", mem_req, 0);
    checkOutput("rst_memread", MemRead, 0);
    checkOutput("rst_irwrite", IRWrite, 0);
    checkOutput("rst_next", nextstate, 0);
    checkOutput("rst_count", instr_count, 0);
    checkOutput("rst_illegal", illegal, 0);
    #3 Reset = 1'b0;
    applyStimulus(6'h00, 1'b0, 1'b0);
    checkOutput("fetch_memreq", mem_req, 1);
    checkOutput("fetch_memread", MemRead, 1);
    checkOutput("fetch_wait_ir", IRWrite, 0);
    checkOutput("fetch_wait_next", nextstate, 0);
    tick();
    checkOutput("fetch_hold", state, 0);
    checkOutput("fetch_nocount", instr_count, 0);

    // ALU instruction
    applyStimulus(6'h00, 1'b0, 1'b1);
    checkOutput("alu_irwrite", IRWrite, 1);
    checkOutput("alu_pcwrite", PCWrite, 1);
    checkOutput("alu_next", nextstate, 1);
    tick();
    applyStimulus(6'h00, 1'b0, 1'b1);
    checkOutput("alu_dec", state, 1);
    checkOutput("alu_dec_memreq", mem_req, 0);
    checkOutput("alu_dec_ir", IRWrite, 0);
    checkOutput("alu_dec_rw", RegWrite, 0);
    tick();
    checkOutput("alu_ex", state, 2);
    checkOutput("alu_ex_op", ALUop, 3);
    checkOutput("alu_ex_rw", RegWrite, 0);
    tick();
    checkOutput("alu_wb", state, 3);
    checkOutput("alu_wb_rw", RegWrite, 1);
    tick();
    applyStimulus(6'h00, 1'b0, 1'b0);
    checkOutput("alu_done", state, 0);
    checkOutput("alu_count", instr_count, 1);

    // LOAD with three wait cycles
    fetchOp(6'h01);
    tick();
    checkOutput("ld_addr", state, 4);
    checkOutput("ld_addr_op", ALUop, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("ld_wait_state", state, 5);
      checkOutput("ld_wait_read", MemRead, 1);
      tick();
    end
    applyStimulus(6'h01, 1'b0, 1'b1);
    checkOutput("ld_last_state", state, 5);
    checkOutput("ld_last_read", MemRead, 1);
    checkOutput("ld_last_next", nextstate, 6);
    tick();
    applyStimulus(6'h01, 1'b0, 1'b0);
    checkOutput("ld_wb", state, 6);
    checkOutput("ld_wb_rw", RegWrite, 1);
    tick();
    checkOutput("ld_done", state, 0);
    checkOutput("ld_count", instr_count, 2);

    // BEQZ not taken, then taken
    fetchOp(6'h03);
    tick();
    checkOutput("bnt_state", state, 8);
    checkOutput("bnt_pc", PCWrite, 0);
    checkOutput("bnt_op", ALUop, 1);
    tick();
    checkOutput("bnt_done", state, 0);
    fetchOp(6'h03);
    tick();
    applyStimulus(6'h03, 1'b1, 1'b0);
    checkOutput("bt_state", state, 8);
    checkOutput("bt_pc", PCWrite, 1);
    tick();
    checkOutput("bt_done", state, 0);
    checkOutput("br_count", instr_count, 4);

    // PUSH
    fetchOp(6'h05);
    tick();
    checkOutput("push_dec", state, 10);
    checkOutput("push_sp", SPWrite, 1);
    checkOutput("push_op", ALUop, 1);
    tick();
    checkOutput("push_wr", state, 11);
    checkOutput("push_mw", MemWrite, 1);
    checkOutput("push_wait_next", nextstate, 11);
    tick();
    applyStimulus(6'h05, 1'b0, 1'b1);
    checkOutput("push_hold", state, 11);
    checkOutput("push_next", nextstate, 0);
    tick();
    applyStimulus(6'h05, 1'b0, 1'b0);
    checkOutput("push_done", state, 0);

    // POP
    fetchOp(6'h06);
    tick();
    applyStimulus(6'h06, 1'b0, 1'b1);
    checkOutput("pop_rd", state, 12);
    checkOutput("pop_read", MemRead, 1);
    tick();
    applyStimulus(6'h06, 1'b0, 1'b0);
    checkOutput("pop_inc", state, 13);
    checkOutput("pop_sp", SPWrite, 1);
    checkOutput("pop_rw", RegWrite, 1);
    checkOutput("pop_op", ALUop, 0);
    tick();
    checkOutput("pop_done", state, 0);
    checkOutput("pp_count", instr_count, 6);

    // JUMP
    fetchOp(6'h04);
    tick();
    checkOutput("jmp_state", state, 9);
    checkOutput("jmp_pc", PCWrite, 1);
    tick();
    checkOutput("jmp_done", state, 0);

    // Illegal opcode
    fetchOp(6'h2A);
    checkOutput("ill_next", nextstate, 0);
    checkOutput("ill_pre", illegal, 0);
    tick();
    checkOutput("ill_state", state, 0);
    checkOutput("ill_flag", illegal, 1);
    checkOutput("ill_count", instr_count, 8);
    tick();
    checkOutput("ill_sticky", illegal, 1);

    // STORE aborted by reset mid-access
    fetchOp(6'h02);
    tick();
    tick();
    checkOutput("st_state", state, 7);
    checkOutput("st_mw", MemWrite, 1);
    checkOutput("st_req", mem_req, 1);
    Reset = 1'b1;
    #1;
    checkOutput("abort_state", state, 0);
    checkOutput("abort_mw", MemWrite, 0);
    checkOutput("abort_req", mem_req, 0);
    checkOutput("abort_count", instr_count, 0);
    checkOutput("abort_illegal", illegal, 0);
    checkOutput("abort_next", nextstate, 0);
    @(negedge Clk);
    Reset = 1'b0;
    tick();

    // One ALU instruction, then HALT for 20 cycles
    fetchOp(6'h00);
    tick();
    tick();
    tick();
    checkOutput("pre_halt_count", instr_count, 1);
    fetchOp(6'h3F);
    checkOutput("halt_next", nextstate, 14);
    tick();
    applyStimulus(6'h00, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      checkOutput("halt_state", state, 14);
      checkOutput("halt_flag", halted, 1);
      checkOutput("halt_req", mem_req, 0);
      tick();
    end
    checkOutput("halt_count", instr_count, 1);
    Reset = 1'b1;
    #1;
    checkOutput("halt_reset_state", state, 0);
    checkOutput("halt_reset_flag", halted, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
